// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder (W = 4*NIBBLES) that time-multiplexes one external 4-bit adder, LSB nibble first.
// Optional signed-overflow output enabled by defining NSA_OVERFLOW_EN.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   busy
`ifdef NSA_OVERFLOW_EN
    ,
    output logic                   out_ovf
`endif
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [IdxW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;
        out_valid = 1'b0;
        out_cout  = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = in_a;
                    b_sh_d  = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                busy    = 1'b1;
                // Adder inputs come only from registers: no in_* to add_* path.
                add_a   = a_sh_q[3:0];
                add_b   = b_sh_q[3:0];
                add_cin = carry_q;
                sum_d[{idx_q, 2'b00} +: 4] = add_s;
                carry_d = add_cout;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_cout  = carry_q;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_sum = sum_q;

`ifdef NSA_OVERFLOW_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        if (state_q == StIdle && in_valid) begin
            a_msb_d = in_a[W-1];
            b_msb_d = in_b[W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign out_ovf = (state_q == StDone) && (a_msb_q == b_msb_q) && (sum_q[W-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder and
// an arithmetic reference model.
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b;
    logic [3:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout;
    logic         out_valid, out_ready, out_cout, busy;
    logic [W-1:0] out_sum;
`ifdef NSA_OVERFLOW_EN
    logic         out_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] seq_a[20];
    logic       seq_c[20];

    always #5 clk = ~clk;

    // External combinational 4-bit adder stage
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
`ifdef NSA_OVERFLOW_EN
        , .out_ovf(out_ovf)
`endif
    );

    function automatic logic [W:0] model_sum(input logic [W-1:0] a, b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, b, input logic c);
        logic [W:0] s;
        s = model_sum(a, b, c);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Starts at a negedge with the DUT idle; ends at the negedge where out_valid is seen.
    task automatic run_op(input logic [W-1:0] a, b, input logic c, output int cycles);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cycles = 0;
        @(negedge clk);
        while (!out_valid && cycles < 20) begin
            seq_a[cycles] = add_a;
            seq_c[cycles] = add_cin;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({in_ready, out_valid, busy, out_cout, add_cin} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got in_ready,out_valid,busy,out_cout,add_cin=%b want 10000",
                     {in_ready, out_valid, busy, out_cout, add_cin});
        end
        n_checks++;
        if ({out_sum, add_a, add_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got out_sum=%h add_a=%h add_b=%h want 0", out_sum, add_a, add_b);
        end
`ifdef NSA_OVERFLOW_EN
        n_checks++;
        if (out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b want 0", out_ovf);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[3] = '{16'h1234, 16'hFFFF, 16'h00FF};
        logic [W-1:0] tb[3] = '{16'h4321, 16'h0001, 16'h0000};
        logic         tc[3] = '{1'b0, 1'b0, 1'b1};
        for (int r = 0; r < 3; r++) begin
            int cyc;
            logic [W:0] exp;
            exp = model_sum(ta[r], tb[r], tc[r]);
            run_op(ta[r], tb[r], tc[r], cyc);
            n_checks++;
            if (cyc !== N) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d edges want %0d", r, cyc, N);
            end
            n_checks++;
            if ({out_cout, out_sum} !== exp) begin
                n_fail++;
                $display("FAIL dir%0d_sum: got %b_%h want %b_%h", r, out_cout, out_sum, exp[W], exp[W-1:0]);
            end
            n_checks++;
            if ({busy, in_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL dir%0d_done_flags: got busy,in_ready=%b want 10", r, {busy, in_ready});
            end
            for (int k = 0; k < N && k < cyc; k++) begin
                logic [W-1:0] mask;
                logic [W:0]   part;
                logic         ec;
                mask = (k == 0) ? '0 : ({W{1'b1}} >> (W - 4 * k));
                part = model_sum(ta[r] & mask, tb[r] & mask, tc[r]);
                ec   = (k == 0) ? tc[r] : part[4 * k];
                n_checks++;
                if (seq_a[k] !== ta[r][4*k +: 4] || seq_c[k] !== ec) begin
                    n_fail++;
                    $display("FAIL dir%0d_add_seq%0d: got add_a=%h add_cin=%b want %h %b",
                             r, k, seq_a[k], seq_c[k], ta[r][4*k +: 4], ec);
                end
            end
            release_out();
            n_checks++;
            if ({in_ready, out_valid, busy} !== 3'b100) begin
                n_fail++;
                $display("FAIL dir%0d_return_idle: got in_ready,out_valid,busy=%b want 100", r,
                         {in_ready, out_valid, busy});
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad = 0;
        logic [W-1:0] a, b;
        logic [W:0]   exp;
        a = W'($urandom); b = W'($urandom);
        exp = model_sum(a, b, 1'b1);
        run_op(a, b, 1'b1, cyc);
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || in_ready || {out_cout, out_sum} !== exp) bad++;
            in_valid = (i == 2);
            in_a = ~a; in_b = ~b;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        end
        n_checks++;
        if ({out_valid, out_cout, out_sum} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL bp_sum: got %b_%h want %b_%h", out_cout, out_sum, exp[W], exp[W-1:0]);
        end
        release_out();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: got in_ready,out_valid=%b want 10", {in_ready, out_valid});
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_accept: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int cyc;
            int wait_n;
            logic [W-1:0] a, b;
            logic         c;
            logic [W:0]   exp;
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            exp = model_sum(a, b, c);
            run_op(a, b, c, cyc);
            wait_n = $urandom_range(0, 3);
            repeat (wait_n) @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp) begin
                n_fail++;
                $display("FAIL rand%0d: %h+%h+%b got v=%b %b_%h want %b_%h", r, a, b, c,
                         out_valid, out_cout, out_sum, exp[W], exp[W-1:0]);
            end
`ifdef NSA_OVERFLOW_EN
            n_checks++;
            if (out_ovf !== model_ovf(a, b, c)) begin
                n_fail++;
                $display("FAIL rand%0d_ovf: got %b want %b", r, out_ovf, model_ovf(a, b, c));
            end
`endif
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] expq[$];
        int nacc = 0, nres = 0, last_acc = -1, cyc = 0;
        out_ready = 1'b1;
        in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
        in_valid = 1'b1;
        while (nres < 4 && cyc < 80) begin
            if (out_valid) begin
                n_checks++;
                if (expq.size() == 0 || {out_cout, out_sum} !== expq[0]) begin
                    n_fail++;
                    $display("FAIL b2b_sum%0d: got %b_%h", nres, out_cout, out_sum);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                nres++;
            end
            if (in_ready && in_valid) begin
                expq.push_back(model_sum(in_a, in_b, in_cin));
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != N + 2) begin
                        n_fail++;
                        $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, N + 2);
                    end
                end
                last_acc = cyc;
                nacc++;
            end else if (!in_ready) begin
                if (nacc < 4) begin
                    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (nres != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 4", nres);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_add();
        int cyc;
        int seen = 0;
        in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_cout, add_cin, add_a, add_b, out_sum} !== {1'b1, 28'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_add: got rdy=%b v=%b busy=%b cout=%b cin=%b a=%h b=%h sum=%h want reset",
                     in_ready, out_valid, busy, out_cout, add_cin, add_a, add_b, out_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_no_valid: got %0d valid cycles want 0", seen);
        end
        run_op(16'h0001, 16'h0001, 1'b0, cyc);
        n_checks++;
        if ({out_valid, out_cout, out_sum} !== {1'b1, 1'b0, 16'h0002}) begin
            n_fail++;
            $display("FAIL rst_after_op: got v=%b %b_%h want 1 0_0002", out_valid, out_cout, out_sum);
        end
        release_out();
    endtask

`ifdef NSA_OVERFLOW_EN
    task automatic test_overflow();
        logic [W-1:0] ta[3] = '{16'h7FFF, 16'h8000, 16'h1234};
        logic [W-1:0] tb[3] = '{16'h0001, 16'h8000, 16'h4321};
        for (int r = 0; r < 3; r++) begin
            int cyc;
            logic [W:0] exp;
            exp = model_sum(ta[r], tb[r], 1'b0);
            run_op(ta[r], tb[r], 1'b0, cyc);
            n_checks++;
            if (out_ovf !== model_ovf(ta[r], tb[r], 1'b0) || out_cout !== exp[W]) begin
                n_fail++;
                $display("FAIL ovf%0d: got ovf=%b cout=%b want %b %b", r, out_ovf, out_cout,
                         model_ovf(ta[r], tb[r], 1'b0), exp[W]);
            end
            release_out();
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_add();
`ifdef NSA_OVERFLOW_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle sequencer that performs a W-bit addition, with W = 4*NIBBLES, by time-multiplexing one external combinational 4-bit ripple-carry adder.
- Operands arrive on a valid/ready input channel.
- Nibbles are presented to the adder LSB-first, one per cycle, with the carry registered between cycles.
- The assembled sum and carry-out leave on a valid/ready output channel.
- The block is both the feeder and the consumer of the 4-bit adder stage.

## Interface
Parameters:
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cin  input  1  carry-in for the whole word
- add_a  output  4  nibble of A driven to the external adder
- add_b  output  4  nibble of B driven to the external adder
- add_cin  output  1  carry driven to the external adder
- add_s  input  4  adder sum, combinational from add_a, add_b and add_cin
- add_cout  input  1  adder carry-out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  W  W-bit sum
- out_cout  output  1  final carry-out
- busy  output  1  high in ADD or DONE
- out_ovf  output  1  signed overflow; present only with NSA_OVERFLOW_EN

## Operation
- One clock domain. Reset is asynchronous, active-low.
- While rst_n is low, all registers clear and the FSM is in IDLE.
- Reset values:
  - in_ready=1.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - busy=0.
  - add_a=0, add_b=0, add_cin=0.
- FSM states are IDLE, ADD and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - latch in_a and in_b into shift registers a_sh and b_sh;
    - set carry_r=in_cin and idx=0;
    - go to ADD.
- ADD:
  - in_ready=0.
  - add_a=a_sh[3:0], add_b=b_sh[3:0], add_cin=carry_r. All three come straight from registers, so there is no input-to-adder path.
  - On each edge:
    - sum_r nibble idx <= add_s;
    - carry_r <= add_cout;
    - a_sh and b_sh shift right by 4;
    - idx++.
  - When idx==NIBBLES-1 at the edge, go to DONE.
- DONE:
  - out_valid=1, out_sum=sum_r, out_cout=carry_r.
  - When out_ready=1 at the edge, the handshake completes and the FSM returns to IDLE.
  - out_valid stays 1 and out_sum/out_cout stay stable until that handshake.
- add_a, add_b and add_cin are 0 outside ADD.
- There is no overlap between operations: in_ready is 0 throughout ADD and DONE.
- Arithmetic is unsigned modulo 2^W. {out_cout,out_sum} = in_a + in_b + in_cin.
- idx is a log2-sized counter. The index never wraps past NIBBLES-1.
- NIBBLES=1 is a legal boundary case: ADD lasts exactly one cycle.
- in_valid during ADD or DONE is ignored and not stored. The upstream block holds it until in_ready.
- Reset asserted mid-ADD or mid-DONE:
  - the operation is abandoned;
  - no out_valid is produced;
  - outputs return to their reset values asynchronously.

## Timing
- Accept edge: call it T0.
- ADD occupies cycles T0+1 .. T0+NIBBLES.
- out_valid rises after edge T0+NIBBLES. With NIBBLES=4, it is visible in the cycle after the 4th ADD edge.
- Minimum initiation interval is NIBBLES+2 cycles from one accept to the next, with out_ready held high.
- in_ready rises in the cycle after the output handshake.
- The external adder must settle within one clk period. The block adds no wait states.

## Configuration
- Macro NSA_OVERFLOW_EN.
  - Defined:
    - the out_ovf port exists;
    - the MSBs of A and B are captured at accept;
    - out_ovf = (a_msb==b_msb) && (sum_r[W-1]!=a_msb), valid with out_valid and cleared by reset.
  - Undefined: the port and its registers are absent, and all other behaviour is identical.

## Test plan
(All scenarios use NIBBLES=4.)
- Basic add: in_a=0x1234, in_b=0x4321, in_cin=0.
  - add_a sequence is 4,3,2,1.
  - out_sum=0x5555, out_cout=0.
  - out_valid 4 edges after accept.
- Full ripple: 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, out_cout=1. add_cin reads 0,1,1,1 across the ADD cycles.
- Carry-in: 0x00FF+0x0000, cin=1 -> out_sum=0x0100, out_cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1 and out_sum stays stable;
  - in_ready stays 0;
  - an in_valid pulse is not accepted;
  - releasing out_ready returns the FSM to IDLE with in_ready=1 the next cycle.
- Reset mid-ADD: drop rst_n in the 2nd ADD cycle.
  - All outputs go to reset values immediately.
  - No out_valid appears.
  - A following 0x0001+0x0001 returns 0x0002.
- With NSA_OVERFLOW_EN:
  - 0x7FFF+0x0001 -> out_ovf=1, out_cout=0.
  - 0x8000+0x8000 -> out_ovf=1, out_cout=1.
  - 0x1234+0x4321 -> out_ovf=0.
